instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of the program counter and the ROM address.
REQ-002 Parameter HALT_ADDR, default 2**ADDR_WIDTH-1: address of the last program instruction.
REQ-003 Parameter WRAP_EN, default 0: 1 makes the PC wrap to 0 after HALT_ADDR; 0 makes the block halt there.
REQ-004 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: fetch-advance enable.
REQ-007 Port romAddressOut, output, ADDR_WIDTH bits: address driven to the program ROM; equals the pc register.
REQ-008 Port romDataIn, input, 4 bits: combinational opcode returned by the program ROM for romAddressOut.
REQ-009 Port instrOut, output, 4 bits: registered opcode presented to the decoder.
REQ-010 Port instrValid, output, 1 bit: instrOut holds an unconsumed instruction.
REQ-011 Port instrReady, input, 1 bit: decoder accepts instrOut this cycle.
REQ-012 Port pcOut, output, ADDR_WIDTH bits: ROM address from which instrOut was fetched.
REQ-013 Port skipRequest, input, 1 bit: single-cycle pulse from the decoder (SNZ taken) requesting that the next fetched instruction be discarded.
REQ-014 Port halted, output, 1 bit: the block has stopped fetching.

Function
REQ-015 The block SHALL implement the states FETCH, ISSUE and HALT, plus an internal skipPending flag.
REQ-016 In FETCH with enable=1 and skipPending=0, the next edge SHALL load instrOut with romDataIn, load pcOut with pc, set instrValid=1 and enter ISSUE.
REQ-017 In FETCH with enable=1 and skipPending=1, the next edge SHALL discard romDataIn, clear skipPending and advance the PC per REQ-020, while instrValid stays 0.
REQ-018 In FETCH with enable=0, the block SHALL hold all state.
REQ-019 In ISSUE, instrValid SHALL stay 1 and instrOut/pcOut stable until a cycle with instrValid=1 and instrReady=1 (transfer); enable=0 SHALL NOT drop instrValid.
REQ-020 On a transfer edge, and on a discard edge per REQ-017, the PC SHALL advance:
- pc!=HALT_ADDR: pc<=pc+1, enter FETCH (a transfer also clears instrValid).
- pc==HALT_ADDR and WRAP_EN=1: pc<=0, enter FETCH.
- pc==HALT_ADDR and WRAP_EN=0: pc holds, enter HALT.
REQ-021 PC arithmetic SHALL be modulo 2**ADDR_WIDTH; no carry out is kept.
REQ-022 A skipRequest pulse SHALL set skipPending in any state except HALT; a pulse while skipPending=1 SHALL be ignored, so skips do not stack.
REQ-023 A skipRequest coincident with a transfer SHALL set skipPending, which applies to the immediately following fetch.
REQ-024 A skipPending flag that is set on entry to HALT SHALL be cleared; a skip that would pass HALT_ADDR with WRAP_EN=0 SHALL enter HALT.
REQ-025 In HALT the block SHALL hold: instrValid=0, halted=1, pc held, skipRequest and enable ignored; only reset exits HALT.
REQ-026 Throughput SHALL be one instruction per 2 cycles when instrReady=1 continuously: a fetch edge, then a transfer edge.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for a clock edge, force:
- state=FETCH, pc=0, pcOut=0;
- instrOut=4'b0111 (CLR/NOP);
- instrValid=0, skipPending=0, halted=0.
REQ-028 Reset asserted mid-handshake or in HALT SHALL discard any pending instruction and skip.
REQ-029 After reset deasserts, the first enabled edge SHALL fetch address 0.

Verification
REQ-030 Straight-line fetch: ROM 0..3 = 0000,0001,1010,0010; enable=1; instrReady=1 -> instrOut 0000,0001,1010,0010 with pcOut 0,1,2,3, one valid every 2 cycles.
REQ-031 Back-pressure: instrReady=0 for 5 cycles while instrOut=0001 at pcOut=1 -> instrValid, instrOut and pcOut remain stable; pc stays 1 until the transfer.
REQ-032 Skip: skipRequest pulsed with the transfer at pcOut=4 -> the instruction at address 5 is never valid; the next valid is address 6. A second pulse while pending -> still only one instruction skipped.
REQ-033 Halt/wrap, ADDR_WIDTH=4, HALT_ADDR=10:
- WRAP_EN=0: after the transfer at pcOut=10, halted=1 and instrValid=0 for 20 cycles.
- WRAP_EN=1: the next pcOut is 0.
REQ-034 Async reset: reset asserted between clock edges while in ISSUE -> outputs go to the REQ-027 values before the next edge; after release, the first enabled edge gives pcOut=0.
REQ-035 Enable gating: enable=0 in FETCH for 3 cycles -> no instrValid and pc unchanged; fetching resumes on the first edge with enable=1.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks the program ROM, hands one opcode at a time to the decoder
// through a valid/ready handshake, honours single-instruction skips and halts or wraps at the end.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned HALT_ADDR  = 2**ADDR_WIDTH - 1,
    parameter bit          WRAP_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] romAddressOut,
    input  logic [3:0]            romDataIn,
    output logic [3:0]            instrOut,
    output logic                  instrValid,
    input  logic                  instrReady,
    output logic [ADDR_WIDTH-1:0] pcOut,
    input  logic                  skipRequest,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] HaltPc = ADDR_WIDTH'(HALT_ADDR);
    localparam logic [3:0]            NopOp  = 4'b0111;

    typedef enum logic [1:0] {
        StFetch,
        StIssue,
        StHalt
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic [3:0]            instr_q, instr_d;
    logic                  skip_q, skip_d;
    logic                  advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StFetch;
            pc_q     <= '0;
            pc_out_q <= '0;
            instr_q  <= NopOp;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            skip_q   <= skip_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        skip_d   = skip_q;
        advance  = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (enable) begin
                    if (skip_q) begin
                        skip_d  = 1'b0;
                        advance = 1'b1;
                    end else begin
                        instr_d  = romDataIn;
                        pc_out_d = pc_q;
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                if (instrReady) begin
                    advance = 1'b1;
                    state_d = StFetch;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase

        // Checked against the pre-edge flag so a pulse during a pending skip never stacks.
        if (state_q != StHalt && skipRequest && !skip_q) begin
            skip_d = 1'b1;
        end

        if (advance) begin
            if (pc_q != HaltPc) begin
                pc_d    = pc_q + 1'b1;
                state_d = StFetch;
            end else if (WRAP_EN) begin
                pc_d    = '0;
                state_d = StFetch;
            end else begin
                state_d = StHalt;
                skip_d  = 1'b0;
            end
        end
    end

    assign romAddressOut = pc_q;
    assign instrOut      = instr_q;
    assign pcOut         = pc_out_q;
    assign instrValid    = (state_q == StIssue);
    assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (halt and wrap variants) share stimulus and are
// checked against a transaction-level model, a directed vector table and corner sequences.
module tb_instruction_fetch;

    localparam int unsigned AW = 4;
    localparam int unsigned HA = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          instr_ready;
    logic          skip_request;
    logic [AW-1:0] rom_addr    [2];
    logic [AW-1:0] pc_out      [2];
    logic [3:0]    rom_data    [2];
    logic [3:0]    instr_out   [2];
    logic          instr_valid [2];
    logic          halted      [2];
    logic [3:0]    rom         [16];

    int total = 0;
    int bad   = 0;

    // Reference model: what the decoder should currently see, per instance (1 = wrap variant).
    int       m_pc    [2];
    int       m_pcout [2];
    int       m_instr [2];
    bit       m_valid [2];
    bit       m_skip  [2];
    bit       m_halt  [2];

    typedef struct {
        bit en;
        bit rdy;
        bit skp;
        bit v;
        int ins;
        int pco;
        int addr;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign rom_data[0] = rom[rom_addr[0]];
    assign rom_data[1] = rom[rom_addr[1]];

    instruction_fetch #(.ADDR_WIDTH(AW), .HALT_ADDR(HA), .WRAP_EN(1'b0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .romAddressOut(rom_addr[0]),
        .romDataIn    (rom_data[0]),
        .instrOut     (instr_out[0]),
        .instrValid   (instr_valid[0]),
        .instrReady   (instr_ready),
        .pcOut        (pc_out[0]),
        .skipRequest  (skip_request),
        .halted       (halted[0])
    );

    instruction_fetch #(.ADDR_WIDTH(AW), .HALT_ADDR(HA), .WRAP_EN(1'b1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .romAddressOut(rom_addr[1]),
        .romDataIn    (rom_data[1]),
        .instrOut     (instr_out[1]),
        .instrValid   (instr_valid[1]),
        .instrReady   (instr_ready),
        .pcOut        (pc_out[1]),
        .skipRequest  (skip_request),
        .halted       (halted[1])
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]    = 0;
            m_pcout[i] = 0;
            m_instr[i] = 7;
            m_valid[i] = 1'b0;
            m_skip[i]  = 1'b0;
            m_halt[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit adv;
            bit old_skip;
            adv      = 1'b0;
            old_skip = m_skip[i];
            if (!m_halt[i]) begin
                if (m_valid[i]) begin
                    if (instr_ready) begin
                        m_valid[i] = 1'b0;
                        adv        = 1'b1;
                    end
                end else if (enable) begin
                    if (m_skip[i]) begin
                        m_skip[i] = 1'b0;
                        adv       = 1'b1;
                    end else begin
                        m_instr[i] = int'(rom[m_pc[i]]);
                        m_pcout[i] = m_pc[i];
                        m_valid[i] = 1'b1;
                    end
                end
                if (skip_request && !old_skip) m_skip[i] = 1'b1;
                if (adv) begin
                    if (m_pc[i] != int'(HA)) begin
                        m_pc[i] = (m_pc[i] + 1) % 16;
                    end else if (i == 1) begin
                        m_pc[i] = 0;
                    end else begin
                        m_halt[i] = 1'b1;
                        m_skip[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d valid", i), int'(instr_valid[i]), int'(m_valid[i]));
            check($sformatf("d%0d instr", i), int'(instr_out[i]), m_instr[i]);
            check($sformatf("d%0d pcOut", i), int'(pc_out[i]), m_pcout[i]);
            check($sformatf("d%0d halted", i), int'(halted[i]), int'(m_halt[i]));
            check($sformatf("d%0d romAddr", i), int'(rom_addr[i]), m_pc[i]);
        end
    endtask

    // Inputs are applied 1 time unit after an edge and held through the next one.
    task automatic cycle(input bit en, input bit rdy, input bit skp);
        enable       = en;
        instr_ready  = rdy;
        skip_request = skp;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_model();
        #1;
        reset = 1'b0;
    endtask

    task automatic add_vec(input bit en, input bit rdy, input bit skp, input bit v,
                           input int ins, input int pco, input int addr);
        vec_t e;
        e.en = en; e.rdy = rdy; e.skp = skp; e.v = v; e.ins = ins; e.pco = pco; e.addr = addr;
        tbl.push_back(e);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        instr_ready  = 1'b0;
        skip_request = 1'b0;
        for (int a = 0; a < 16; a++) rom[a] = 4'($urandom_range(15));
        rom[0] = 4'h0; rom[1] = 4'h1; rom[2] = 4'hA; rom[3] = 4'h2;
        rom[4] = 4'h5; rom[5] = 4'h3; rom[6] = 4'h9; rom[7] = 4'hC;

        // Straight line, back-pressure, transfer with enable low, enable gating, skip.
        add_vec(1, 1, 0, 1, 4'h0, 0, 0);
        add_vec(1, 1, 0, 0, 4'h0, 0, 1);
        add_vec(1, 0, 0, 1, 4'h1, 1, 1);
        for (int k = 0; k < 5; k++) add_vec(1, 0, 0, 1, 4'h1, 1, 1);
        add_vec(0, 1, 0, 0, 4'h1, 1, 2);
        add_vec(1, 1, 0, 1, 4'hA, 2, 2);
        add_vec(1, 1, 0, 0, 4'hA, 2, 3);
        add_vec(1, 1, 0, 1, 4'h2, 3, 3);
        add_vec(1, 1, 0, 0, 4'h2, 3, 4);
        for (int k = 0; k < 3; k++) add_vec(0, 0, 0, 0, 4'h2, 3, 4);
        add_vec(1, 0, 0, 1, 4'h5, 4, 4);
        add_vec(1, 1, 1, 0, 4'h5, 4, 5);
        add_vec(1, 1, 1, 0, 4'h5, 4, 6);
        add_vec(1, 1, 0, 1, 4'h9, 6, 6);
        add_vec(1, 1, 0, 0, 4'h9, 6, 7);
        add_vec(1, 1, 0, 1, 4'hC, 7, 7);

        #1;
        do_reset();
        foreach (tbl[k]) begin
            cycle(tbl[k].en, tbl[k].rdy, tbl[k].skp);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("vec%0d d%0d valid", k, i), int'(instr_valid[i]), int'(tbl[k].v));
                check($sformatf("vec%0d d%0d instr", k, i), int'(instr_out[i]), tbl[k].ins);
                check($sformatf("vec%0d d%0d pcOut", k, i), int'(pc_out[i]), tbl[k].pco);
                check($sformatf("vec%0d d%0d addr", k, i), int'(rom_addr[i]), tbl[k].addr);
            end
        end

        // Run up to the last instruction, then halt (dut0) or wrap (dut1).
        for (int k = 0; k < 6; k++) cycle(1, 1, 0);
        check("issue at halt addr", int'(pc_out[0]), 10);
        cycle(1, 1, 0);
        check("halted after last", int'(halted[0]), 1);
        cycle(1, 1, 0);
        check("wrap pcOut", int'(pc_out[1]), 0);
        check("wrap valid", int'(instr_valid[1]), 1);
        for (int k = 0; k < 20; k++) begin
            cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            check("halt holds", int'(halted[0]), 1);
            check("halt no valid", int'(instr_valid[0]), 0);
            check("halt pc held", int'(rom_addr[0]), 10);
        end

        // Reset in HALT, then a skip that discards the last address.
        do_reset();
        check("reset leaves halt", int'(halted[0]), 0);
        for (int k = 0; k < 19; k++) cycle(1, 1, 0);
        cycle(1, 1, 1);
        cycle(1, 1, 0);
        check("skip into halt", int'(halted[0]), 1);
        check("skip wraps addr", int'(rom_addr[1]), 0);
        cycle(1, 1, 0);
        check("after wrap skip pcOut", int'(pc_out[1]), 0);
        check("after wrap skip valid", int'(instr_valid[1]), 1);

        // Asynchronous reset between edges while issuing.
        do_reset();
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        check("pre-reset pcOut", int'(pc_out[0]), 1);
        reset = 1'b1;
        #2;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check("async instr", int'(instr_out[i]), 7);
            check("async valid", int'(instr_valid[i]), 0);
            check("async pcOut", int'(pc_out[i]), 0);
            check("async addr", int'(rom_addr[i]), 0);
            check("async halted", int'(halted[i]), 0);
        end
        reset = 1'b0;
        cycle(1, 0, 0);
        check("first fetch after reset", int'(pc_out[0]), 0);
        check("first fetch valid", int'(instr_valid[0]), 1);

        // Random traffic with occasional resets and fresh ROM contents.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 2) begin
                for (int a = 0; a < 16; a++) rom[a] = 4'($urandom_range(15));
                do_reset();
            end else begin
                cycle(1'($urandom_range(99) < 75), 1'($urandom_range(99) < 60),
                      1'($urandom_range(99) < 15));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
